// File: rtl/fa_cache_pkg.sv
// Shared types and line-format constants for the fully associative cache
// refill controller and its fill assembler.
package fa_cache_pkg;

  localparam int LINE_W         = 141;
  localparam int VALID_BIT      = 140;
  localparam int TAG_HI         = 139;
  localparam int TAG_LO         = 128;
  localparam int TAG_W          = 12;
  localparam int WORDS_PER_LINE = 4;
  localparam int WORD_W         = 32;
  localparam int DATA_W         = WORDS_PER_LINE * WORD_W;

  // One array entry: {valid, tag, data}, word 0 in the top 32 data bits.
  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOOKUP,
    ST_MEM_REQ,
    ST_FILL,
    ST_WRITE,
    ST_RESP
  } refill_state_e;

  // Packs a line in the array's write-port format.
  function automatic line_t make_line(input logic              valid,
                                      input logic [TAG_W-1:0]  tag,
                                      input logic [DATA_W-1:0] data);
    return {valid, tag, data};
  endfunction

endpackage

// File: rtl/fa_fill_assembler.sv
// Collects the four memory beats of a line fetch. Beats arrive in address
// order and are shifted in from the bottom, so after the last beat word 0
// sits at the top of line_data. done is high in the cycle the final beat is
// accepted, so the assembled line is complete from the following cycle.
module fa_fill_assembler
  import fa_cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              beat_valid,
  input  logic [WORD_W-1:0] beat_data,
  output logic [DATA_W-1:0] line_data,
  output logic              done
);

  logic [1:0]        beat_cnt_q;
  logic [DATA_W-1:0] data_q;

  // Beat counter and shift register; clear starts a fresh line.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      beat_cnt_q <= '0;
      data_q     <= '0;
    end else if (beat_valid) begin
      beat_cnt_q <= beat_cnt_q + 2'd1;
      data_q     <= {data_q[DATA_W-WORD_W-1:0], beat_data};
    end
  end

  assign line_data = data_q;
  assign done      = beat_valid && (beat_cnt_q == 2'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/fa_cache_refill_ctrl.sv
// Request front-end and miss handler for the fully associative line array.
// Clears the array after reset, then serves one load at a time: a hit
// returns the looked-up word, a miss fetches the line, writes it into a
// round-robin victim slot and replays the lookup.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. A source holds valid and its payload stable until that
// edge; ready may be asserted independently of valid.
module fa_cache_refill_ctrl
  import fa_cache_pkg::*;
#(
  parameter int NUM_LINES = 256,
  parameter int ADDR_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_W-1:0]            req_addr,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [31:0]                  resp_data,
  output logic                         resp_miss,
  output logic [ADDR_W-1:0]            lkp_addr,
  input  logic                         lkp_hit,
  input  logic [31:0]                  lkp_data,
  output logic                         fill_we,
  output logic [$clog2(NUM_LINES)-1:0] fill_idx,
  output logic [LINE_W-1:0]            fill_line,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [ADDR_W-5:0]            mem_req_addr,
  input  logic                         mem_rsp_valid,
  input  logic [31:0]                  mem_rsp_data,
  output logic [15:0]                  hit_count,
  output logic [15:0]                  miss_count,
  output logic [2:0]                   dbg_state
);

  localparam int IDX_W = $clog2(NUM_LINES);

  refill_state_e     state_q, state_d;
  logic [IDX_W-1:0]  init_idx_q;
  logic [IDX_W-1:0]  victim_q;
  logic [ADDR_W-1:0] addr_q;
  logic              miss_q;
  logic [31:0]       resp_data_q;
  logic [15:0]       hit_cnt_q;
  logic [15:0]       miss_cnt_q;

  logic              asm_clear;
  logic              asm_beat;
  logic              asm_done;
  logic [DATA_W-1:0] asm_data;

  logic              lookup_hit;
  logic              lookup_miss;

  assign asm_clear   = (state_q == ST_MEM_REQ) && mem_req_ready;
  assign asm_beat    = (state_q == ST_FILL) && mem_rsp_valid;
  assign lookup_hit  = (state_q == ST_LOOKUP) && lkp_hit;
  assign lookup_miss = (state_q == ST_LOOKUP) && !lkp_hit;

  fa_fill_assembler u_assembler (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .beat_valid (asm_beat),
    .beat_data  (mem_rsp_data),
    .line_data  (asm_data),
    .done       (asm_done)
  );

  // State register; reset always restarts the array clear.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  // Next state and per-state outputs.
  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    mem_req_valid = 1'b0;
    fill_we       = 1'b0;
    fill_idx      = '0;
    fill_line     = '0;
    case (state_q)
      ST_INIT: begin
        fill_we  = 1'b1;
        fill_idx = init_idx_q;
        if (init_idx_q == IDX_W'(NUM_LINES - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        state_d = lkp_hit ? ST_RESP : ST_MEM_REQ;
      end
      ST_MEM_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (asm_done) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        fill_we   = 1'b1;
        fill_idx  = victim_q;
        fill_line = make_line(1'b1, addr_q[ADDR_W-1:4], asm_data);
        state_d   = ST_LOOKUP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Clear index walks every line once; it wraps back to 0 as INIT ends.
  always_ff @(posedge clk) begin
    if (rst)                      init_idx_q <= '0;
    else if (state_q == ST_INIT)  init_idx_q <= init_idx_q + 1'b1;
  end

  // Round-robin victim pointer; NUM_LINES is a power of two so it wraps freely.
  always_ff @(posedge clk) begin
    if (rst)                      victim_q <= '0;
    else if (state_q == ST_WRITE) victim_q <= victim_q + 1'b1;
  end

  // Request capture and miss flag; the flag also marks the replay lookup.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      miss_q <= 1'b0;
    end else if (state_q == ST_IDLE && req_valid) begin
      addr_q <= req_addr;
      miss_q <= 1'b0;
    end else if (lookup_miss) begin
      miss_q <= 1'b1;
    end
  end

  // Response word is registered on a hit and held through RESP.
  always_ff @(posedge clk) begin
    if (rst)             resp_data_q <= '0;
    else if (lookup_hit) resp_data_q <= lkp_data;
  end

  // Saturating statistics; the replay hit after a fill is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (lookup_hit && !miss_q && hit_cnt_q != 16'hFFFF)
        hit_cnt_q <= hit_cnt_q + 16'd1;
      if (lookup_miss && miss_cnt_q != 16'hFFFF)
        miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign lkp_addr     = addr_q;
  assign mem_req_addr = addr_q[ADDR_W-1:4];
  assign resp_data    = resp_data_q;
  assign resp_miss    = miss_q;
  assign hit_count    = hit_cnt_q;
  assign miss_count   = miss_cnt_q;
  assign dbg_state    = state_q;

endmodule
